// File: rtl/image_loader.sv
// image_loader: fills the display framebuffer from a raster-ordered byte
// stream. One write per accepted byte at sequential addresses, with a stall
// timeout so a broken stream cannot leave the loader stuck in LOAD.
//
// Optional build macro IMAGE_LOADER_CHECKSUM_EN: when defined, checksum is a
// registered mod-256 sum of the bytes accepted since the last start. When it
// is not defined, checksum is tied to zero and the port list is unchanged.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_LOAD  | accepting bytes, one framebuffer write per handshake
// ST_DONE  | last pixel written, frame complete; start reloads
// ST_ERROR | stream stalled for TIMEOUT_CYCLES; start reloads

module image_loader #(
   parameter int IMAGE_WIDTH    = 400,
   parameter int IMAGE_HEIGHT   = 400,
   parameter int ADDR_W         = 19,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        checksum
);

   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] pix_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              hs;
   logic              pix_last;
   logic              to_hit;

   // A restart cycle never accepts a byte, so start masks ready.
   assign in_ready = (state == ST_LOAD) && !start;
   assign hs       = in_valid && in_ready;
   assign pix_last = (pix_cnt == PIX_LAST);
   assign to_hit   = (to_cnt == TO_LAST);

   assign busy  = (state == ST_LOAD);
   assign done  = (state == ST_DONE);
   assign error = (state == ST_ERROR);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: start wins over handshake and timeout in every state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD: begin
            if (start) begin
               state_nxt = ST_LOAD;
            end else if (hs && pix_last) begin
               state_nxt = ST_DONE;
            end else if (!hs && to_hit) begin
               state_nxt = ST_ERROR;
            end
         end
         default: begin
            if (start) begin
               state_nxt = ST_LOAD;
            end
         end
      endcase
   end

   // Pixel/timeout counters and the registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt <= '0;
         to_cnt  <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= 8'h00;
      end else begin
         wr_en <= 1'b0;
         if (start) begin
            pix_cnt <= '0;
            to_cnt  <= '0;
         end else if (state == ST_LOAD) begin
            if (hs) begin
               wr_en   <= 1'b1;
               wr_addr <= pix_cnt;
               wr_data <= in_data;
               pix_cnt <= pix_cnt + ADDR_W'(1);
               to_cnt  <= '0;
            end else if (!to_hit) begin
               to_cnt <= to_cnt + TO_W'(1);
            end
         end
      end
   end

`ifdef IMAGE_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   // Running sum of accepted bytes, updated on the same edge as the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= 8'h00;
      end else if (start) begin
         csum <= 8'h00;
      end else if (hs) begin
         csum <= csum + in_data;
      end
   end

   assign checksum = csum;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with a 4x2 frame and a 16-cycle timeout.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled there too, so every sample reflects the edge just taken.

module tb_image_loader;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 4;
   localparam int TO = 16;

`ifdef IMAGE_LOADER_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;
   logic          done;
   logic          error;
   logic [7:0]    checksum;

   int total = 0;
   int bad   = 0;

   image_loader #(
      .IMAGE_WIDTH   (W),
      .IMAGE_HEIGHT  (H),
      .ADDR_W        (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .checksum(checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] cs_exp(input logic [7:0] v);
      return CS_EN ? v : 8'h00;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] sum;
      logic       exp_we;
      int         nwr;

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset followed by 5 idle cycles.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_wr_en", wr_en, 0);
         check("idle_in_ready", in_ready, 0);
      end
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_checksum", checksum, 0);

      // Full frame, back-to-back bytes 0x10..0x17.
      pulse_start();
      check("full_busy", busy, 1);
      in_valid = 1'b1;
      sum = 8'h00;
      for (int i = 0; i < W * H; i++) begin
         in_data = 8'h10 + 8'(i);
         sum     = sum + in_data;
         tick();
         check("full_wr_en", wr_en, 1);
         check("full_wr_addr", wr_addr, i);
         check("full_wr_data", wr_data, 8'h10 + 8'(i));
         check("full_done", done, (i == W * H - 1) ? 1 : 0);
      end
      in_valid = 1'b0;
      check("full_sum_const", {24'h0, sum}, 32'h9C);
      check("full_checksum", checksum, cs_exp(8'h9C));
      check("full_busy_end", busy, 0);
      tick();
      check("full_wr_en_after", wr_en, 0);
      check("full_done_hold", done, 1);

      // Toggled valid: three bytes on alternate cycles.
      pulse_start();
      check("tog_done_clear", done, 0);
      exp_we = 1'b0;
      nwr    = 0;
      for (int k = 0; k < 6; k++) begin
         in_valid = (k % 2 == 0);
         in_data  = 8'h20 + 8'(k / 2);
         tick();
         exp_we = (k % 2 == 0);
         check("tog_wr_en", wr_en, exp_we);
         if (exp_we) begin
            check("tog_wr_addr", wr_addr, nwr);
            check("tog_wr_data", wr_data, 8'h20 + 8'(nwr));
            nwr++;
         end
         check("tog_busy", busy, 1);
         check("tog_done", done, 0);
      end
      in_valid = 1'b0;
      check("tog_checksum", checksum, cs_exp(8'h20 + 8'h21 + 8'h22));

      // Two bytes, then stall into timeout.
      pulse_start();
      in_valid = 1'b1;
      in_data  = 8'h30;
      tick();
      in_data = 8'h31;
      tick();
      check("to_last_wr_addr", wr_addr, 1);
      in_valid = 1'b0;
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         check("to_no_error_yet", error, 0);
         check("to_no_write", wr_en, 0);
      end
      tick();
      check("to_error", error, 1);
      check("to_busy", busy, 0);
      in_valid = 1'b1;
      in_data  = 8'h99;
      #1;
      check("err_in_ready", in_ready, 0);
      tick();
      check("err_wr_en", wr_en, 0);
      check("err_error_hold", error, 1);
      in_data = 8'h40;
      pulse_start();
      check("rec_busy", busy, 1);
      check("rec_error", error, 0);
      tick();
      check("rec_wr_en", wr_en, 1);
      check("rec_wr_addr", wr_addr, 0);
      check("rec_wr_data", wr_data, 8'h40);
      check("rec_checksum", checksum, cs_exp(8'h40));
      in_valid = 1'b0;

      // Restart mid-load after address 5 has been written.
      pulse_start();
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 8'h50 + 8'(i);
         tick();
      end
      check("mid_wr_addr5", wr_addr, 5);
      start   = 1'b1;
      in_data = 8'h77;
      #1;
      check("mid_in_ready", in_ready, 0);
      tick();
      start = 1'b0;
      check("mid_no_write", wr_en, 0);
      check("mid_busy", busy, 1);
      check("mid_checksum_clr", checksum, 0);
      in_data = 8'h60;
      tick();
      check("mid_wr_en", wr_en, 1);
      check("mid_wr_addr", wr_addr, 0);
      check("mid_wr_data", wr_data, 8'h60);
      check("mid_checksum", checksum, cs_exp(8'h60));
      in_valid = 1'b0;

      // Asynchronous reset while loading, after address 3 is written.
      pulse_start();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'h80 + 8'(i);
         tick();
      end
      check("ar_wr_addr3", wr_addr, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_wr_en", wr_en, 0);
      check("ar_wr_addr", wr_addr, 0);
      check("ar_wr_data", wr_data, 0);
      check("ar_busy", busy, 0);
      check("ar_in_ready", in_ready, 0);
      check("ar_checksum", checksum, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ar_ignore_wr", wr_en, 0);
         check("ar_ignore_ready", in_ready, 0);
         check("ar_idle_busy", busy, 0);
      end
      in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
